jk_cmd_seq: RTL

- Command sequencer directly upstream of the team's JK flip-flop.
- Accepts hold/clear/set/toggle commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered j/k to the flip-flop for a programmable number of cycles per command.
- Keeps a shadow copy of the flip-flop's q so the controller can read the expected state without a feedback path.

---
 rtl/jk_cmd_seq_if.sv | 13 +
 rtl/jk_cmd_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/jk_cmd_seq_if.sv
// Command handshake bundle between the controller and jk_cmd_seq.
// The master is the controller side and the slave is the sequencer side.
interface jk_cmd_seq_if #(
   parameter int CNT_W = 4
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;

   modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/jk_cmd_seq.sv
// Buffers JK commands in a small FIFO and drives registered j/k for cnt+1 cycles each.
// It also tracks a shadow copy of the downstream flip-flop's q.
module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   jk_cmd_seq_if.slave              cmd,
   output logic                     j,
   output logic                     k,
   output logic                     busy,
   output logic                     shadow_q,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 + CNT_W;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t           state, state_nxt;
   logic [EW-1:0]    mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0] remaining, remaining_nxt;
   logic             j_nxt, k_nxt;
   logic             ready_en, full, empty, push, pop;
   logic [EW-1:0]    head;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];
   assign busy  = (state == ISSUE);

   // ready_en keeps cmd_ready low through reset and until the first edge after release
   assign cmd.cmd_ready = ready_en && !full;
   assign push          = cmd.cmd_valid && cmd.cmd_ready;

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {cmd.cmd_op, cmd.cmd_cnt};
      end
   end

   // Next-state logic. On the final cycle of a command, the next queued command is
   // loaded immediately, so no 00 bubble appears between them.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      j_nxt         = j;
      k_nxt         = k;
      pop           = 1'b0;
      case (state)
         IDLE: begin
            j_nxt = 1'b0;
            k_nxt = 1'b0;
            if (!empty) begin
               pop            = 1'b1;
               {j_nxt, k_nxt} = head[EW-1:CNT_W];
               remaining_nxt  = head[CNT_W-1:0];
               state_nxt      = ISSUE;
            end
         end
         ISSUE: begin
            if (remaining != '0) begin
               remaining_nxt = remaining - CNT_W'(1);
            end else if (!empty) begin
               pop            = 1'b1;
               {j_nxt, k_nxt} = head[EW-1:CNT_W];
               remaining_nxt  = head[CNT_W-1:0];
            end else begin
               state_nxt = IDLE;
               j_nxt     = 1'b0;
               k_nxt     = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            j_nxt     = 1'b0;
            k_nxt     = 1'b0;
         end
      endcase
   end

   // shadow_q samples the same registered j/k on the same edge as the real flip-flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         j         <= 1'b0;
         k         <= 1'b0;
         shadow_q  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ready_en  <= 1'b0;
      end else begin
         ready_en  <= 1'b1;
         state     <= state_nxt;
         remaining <= remaining_nxt;
         j         <= j_nxt;
         k         <= k_nxt;
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         case ({j, k})
            2'b01:   shadow_q <= 1'b0;
            2'b10:   shadow_q <= 1'b1;
            2'b11:   shadow_q <= ~shadow_q;
            default: shadow_q <= shadow_q;
         endcase
      end
   end
endmodule
